// File: rtl/fetch_queue.sv
// Sequential instruction fetcher feeding a circular FIFO of {pc, instruction} pairs.
// A redirect empties the FIFO and drops any fetch that is still in flight.
module fetch_queue #(
    parameter int               width    = 32,
    parameter int               size     = 8,
    parameter logic [width-1:0] reset_pc = width'(32'h0000_0060)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_read,
    output logic [width-1:0]     imem_address,
    input  logic                 imem_resp,
    input  logic [width-1:0]     imem_rdata,
    input  logic                 flush,
    input  logic [width-1:0]     flush_pc,
    input  logic                 instr_q_dequeue,
    output logic                 instr_q_empty,
    output logic [2*width-1:0]   instr_q_data
);

    localparam int ptr_w = (size > 1) ? $clog2(size) : 1;
    localparam int cnt_w = ptr_w + 1;

    localparam logic [cnt_w-1:0] cnt_zero = {cnt_w{1'b0}};
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(size);
    localparam logic [ptr_w-1:0] ptr_zero = {ptr_w{1'b0}};
    localparam logic [ptr_w-1:0] ptr_one  = ptr_w'(1'b1);
    localparam logic [width-1:0] pc_step  = width'(3'd4);

    typedef struct packed {
        logic [width-1:0] pc;
        logic [width-1:0] instr;
    } pci_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   pc_q, pc_d;
    logic [width-1:0]   drop_addr_q, drop_addr_d;
    logic [ptr_w-1:0]   front_q, front_d;
    logic [ptr_w-1:0]   rear_q, rear_d;
    logic [cnt_w-1:0]   count_q, count_d;
    pci_t               arr_q [size];
    logic               enq_s;
    logic               deq_s;

    // Next-state, pointer and fetch-PC computation; flush overrides enqueue and dequeue.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        front_d     = front_q;
        rear_d      = rear_q;
        count_d     = count_q;
        enq_s       = 1'b0;
        deq_s       = 1'b0;
        if (flush) begin
            front_d = ptr_zero;
            rear_d  = ptr_zero;
            count_d = cnt_zero;
            pc_d    = flush_pc;
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    // Without a response the old request is still owed; keep presenting it.
                    if (imem_resp) begin
                        state_d = FETCH;
                    end else begin
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end
                end
                DROP: begin
                    if (imem_resp) begin
                        state_d = FETCH;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            enq_s   = (state_q == FETCH) && imem_resp;
            deq_s   = instr_q_dequeue && (count_q != cnt_zero);
            count_d = count_q + cnt_w'(enq_s) - cnt_w'(deq_s);
            if (enq_s) begin
                rear_d = rear_q + ptr_one;
                pc_d   = pc_q + pc_step;
            end else begin
                rear_d = rear_q;
                pc_d   = pc_q;
            end
            if (deq_s) begin
                front_d = front_q + ptr_one;
            end else begin
                front_d = front_q;
            end
            case (state_q)
                IDLE: begin
                    if (count_d < full_cnt) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FETCH: begin
                    if (enq_s && (count_d == full_cnt)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (!imem_resp) begin
                        state_d = DROP;
                    end else if (count_d < full_cnt) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control, pointer and fetch-address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= reset_pc;
            drop_addr_q <= {width{1'b0}};
            front_q     <= ptr_zero;
            rear_q      <= ptr_zero;
            count_q     <= cnt_zero;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            front_q     <= front_d;
            rear_q      <= rear_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; an accepted response is written at the rear slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < size; i++) begin
                arr_q[i] <= {(2*width){1'b0}};
            end
        end else if (enq_s) begin
            arr_q[rear_q] <= {pc_q, imem_rdata};
        end else begin
            arr_q[rear_q] <= arr_q[rear_q];
        end
    end

    // Memory request and first-word fall-through consumer outputs.
    always_comb begin
        imem_read = (state_q != IDLE);
        if (state_q == DROP) begin
            imem_address = drop_addr_q;
        end else begin
            imem_address = pc_q;
        end
        instr_q_empty = (count_q == cnt_zero);
        if (count_q == cnt_zero) begin
            instr_q_data = {(2*width){1'b0}};
        end else begin
            instr_q_data = arr_q[front_q];
        end
    end

endmodule
